// File: rtl/conv3x3_stream_filter_v2.sv
// conv3x3_stream_filter_v2
// 3x3 signed-kernel convolution over an Avalon-ST pixel stream with
// ready/valid backpressure. The design has two pipeline stages: stage 1 holds
// the raw sum and flags, and stage 2 is the output register.
// The kernel and mode are latched per frame. An accepted SOP resynchronises
// the position to (0,0). Malformed SOP/EOP positions produce a one-cycle
// frame_error pulse.
module conv3x3_stream_filter_v2 #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int SHIFT  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [COEF_W-1:0] k11,
    input  logic signed [COEF_W-1:0] k12,
    input  logic signed [COEF_W-1:0] k13,
    input  logic signed [COEF_W-1:0] k21,
    input  logic signed [COEF_W-1:0] k22,
    input  logic signed [COEF_W-1:0] k23,
    input  logic signed [COEF_W-1:0] k31,
    input  logic signed [COEF_W-1:0] k32,
    input  logic signed [COEF_W-1:0] k33,
    input  logic                     mode_abs,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     startofpacket_in,
    input  logic                     endofpacket_in,
    input  logic                     valid_in,
    output logic                     ready_out,
    output logic [DATA_W-1:0]        data_out,
    output logic                     startofpacket_out,
    output logic                     endofpacket_out,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic                     frame_error
);

    localparam int COL_W  = $clog2(WIDTH);
    localparam int ROW_W  = $clog2(HEIGHT);
    localparam int PROD_W = DATA_W + COEF_W + 1;
    localparam int SUM_W  = DATA_W + COEF_W + 5;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
    localparam logic signed [SUM_W-1:0] PIX_MAX = SUM_W'((2 ** DATA_W) - 1);

    // Handshake
    logic w_advance;
    logic w_accept;

    // Position tracking
    logic [COL_W-1:0] r_col;
    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] r_row;
    logic [ROW_W-1:0] w_row;
    logic             w_at_last;
    logic             w_at_origin;
    logic             w_in_window;
    logic             w_win_first;
    logic             w_counters_nonzero;

    // Line memories (row r-1 and row r-2) and column history
    logic [DATA_W-1:0] r_lb1 [WIDTH];
    logic [DATA_W-1:0] r_lb2 [WIDTH];
    logic [DATA_W-1:0] w_lb1_rd;
    logic [DATA_W-1:0] w_lb2_rd;
    logic [DATA_W-1:0] w_col_new [3];
    logic [DATA_W-1:0] r_win [3][2];

    // Per-frame kernel and mode
    logic signed [COEF_W-1:0] w_k_in [9];
    logic signed [COEF_W-1:0] r_k [9];
    logic                     r_mode;

    // Arithmetic
    logic [DATA_W-1:0]        w_tap [9];
    logic signed [PROD_W-1:0] w_prod [9];
    logic signed [SUM_W-1:0]  w_sum;

    // Stage 1
    logic                    r_s1_valid;
    logic signed [SUM_W-1:0] r_s1_sum;
    logic                    r_s1_sop;
    logic                    r_s1_eop;
    logic                    r_s1_mode;

    // Stage 2 post-processing and output registers
    logic signed [SUM_W-1:0] w_rounded;
    logic signed [SUM_W-1:0] w_mag;
    logic [DATA_W-1:0]       w_pix;
    logic                    r_valid_out;
    logic [DATA_W-1:0]       r_data_out;
    logic                    r_sop_out;
    logic                    r_eop_out;
    logic                    r_frame_error;

    assign w_advance = !r_valid_out || ready_in;
    assign w_accept  = valid_in && w_advance;
    assign ready_out = w_advance;

    assign valid_out         = r_valid_out;
    assign data_out          = r_data_out;
    assign startofpacket_out = r_sop_out;
    assign endofpacket_out   = r_eop_out;
    assign frame_error       = r_frame_error;

    assign w_k_in[0] = k11;
    assign w_k_in[1] = k12;
    assign w_k_in[2] = k13;
    assign w_k_in[3] = k21;
    assign w_k_in[4] = k22;
    assign w_k_in[5] = k23;
    assign w_k_in[6] = k31;
    assign w_k_in[7] = k32;
    assign w_k_in[8] = k33;

    // Effective position of the current beat: an SOP overrides the counters.
    always_comb begin
        w_col = r_col;
        w_row = r_row;
        if (startofpacket_in) begin
            w_col = '0;
            w_row = '0;
        end
    end

    assign w_at_last          = (w_row == ROW_LAST) && (w_col == COL_LAST);
    assign w_at_origin        = (w_row == '0) && (w_col == '0);
    assign w_in_window        = (w_row >= ROW_W'(2)) && (w_col >= COL_W'(2));
    assign w_win_first        = (w_row == ROW_W'(2)) && (w_col == COL_W'(2));
    assign w_counters_nonzero = (r_row != '0) || (r_col != '0);

    // Column/row counters: advance per accepted beat, wrap at frame end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
        end
    end

    assign w_lb1_rd = r_lb1[w_col];
    assign w_lb2_rd = r_lb2[w_col];

    // Line memories: the current column moves down one row on each accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_lb1[i] <= '0;
                r_lb2[i] <= '0;
            end
        end else if (w_accept) begin
            r_lb2[w_col] <= w_lb1_rd;
            r_lb1[w_col] <= data_in;
        end
    end

    assign w_col_new[0] = w_lb2_rd;
    assign w_col_new[1] = w_lb1_rd;
    assign w_col_new[2] = data_in;

    // Window history: columns c-2 and c-1 for rows r-2, r-1 and r.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                r_win[i][0] <= '0;
                r_win[i][1] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < 3; i++) begin
                r_win[i][0] <= r_win[i][1];
                r_win[i][1] <= w_col_new[i];
            end
        end
    end

    // Kernel and mode are captured on the first pixel of each frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) begin
                r_k[i] <= '0;
            end
            r_mode <= 1'b0;
        end else if (w_accept && w_at_origin) begin
            for (int i = 0; i < 9; i++) begin
                r_k[i] <= w_k_in[i];
            end
            r_mode <= mode_abs;
        end
    end

    // Row-major taps; the bottom-right tap is the live input pixel.
    assign w_tap[0] = r_win[0][0];
    assign w_tap[1] = r_win[0][1];
    assign w_tap[2] = w_lb2_rd;
    assign w_tap[3] = r_win[1][0];
    assign w_tap[4] = r_win[1][1];
    assign w_tap[5] = w_lb1_rd;
    assign w_tap[6] = r_win[2][0];
    assign w_tap[7] = r_win[2][1];
    assign w_tap[8] = data_in;

    // Unsigned pixels are zero-extended so the products are signed.
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_prod
            assign w_prod[gi] =
                $signed({{(PROD_W - DATA_W){1'b0}}, w_tap[gi]}) *
                $signed({{(PROD_W - COEF_W){r_k[gi][COEF_W-1]}}, r_k[gi]});
        end
    endgenerate

    // Sign-extended accumulation of the nine products.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 9; i++) begin
            w_sum = w_sum + {{(SUM_W - PROD_W){w_prod[i][PROD_W-1]}}, w_prod[i]};
        end
    end

    // Stage 1: register the sum together with the frame flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_sop   <= 1'b0;
            r_s1_eop   <= 1'b0;
            r_s1_mode  <= 1'b0;
        end else if (w_advance) begin
            r_s1_valid <= w_accept && w_in_window;
            r_s1_sum   <= w_sum;
            r_s1_sop   <= w_win_first;
            r_s1_eop   <= w_at_last;
            r_s1_mode  <= r_mode;
        end
    end

    // Round-half-up normalisation shift.
    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [SUM_W-1:0] RND = SUM_W'(2 ** (SHIFT - 1));
            assign w_rounded = (r_s1_sum + RND) >>> SHIFT;
        end else begin : g_no_round
            assign w_rounded = r_s1_sum;
        end
    endgenerate

    // Optional magnitude, then clamp to the unsigned pixel range.
    always_comb begin
        w_mag = w_rounded;
        if (r_s1_mode && w_rounded[SUM_W-1]) begin
            w_mag = -w_rounded;
        end
        if (w_mag[SUM_W-1]) begin
            w_pix = '0;
        end else if (w_mag > PIX_MAX) begin
            w_pix = '1;
        end else begin
            w_pix = w_mag[DATA_W-1:0];
        end
    end

    // Stage 2: the output register. It holds while downstream stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid_out <= 1'b0;
            r_data_out  <= '0;
            r_sop_out   <= 1'b0;
            r_eop_out   <= 1'b0;
        end else if (w_advance) begin
            r_valid_out <= r_s1_valid;
            r_sop_out   <= r_s1_valid && r_s1_sop;
            r_eop_out   <= r_s1_valid && r_s1_eop;
            if (r_s1_valid) begin
                r_data_out <= w_pix;
            end
        end
    end

    // Single-cycle error pulse for an SOP or EOP seen at the wrong position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_error <= 1'b0;
        end else begin
            r_frame_error <= w_accept &&
                ((startofpacket_in && w_counters_nonzero) ||
                 (endofpacket_in && !w_at_last));
        end
    end

endmodule

// File: doc/conv3x3_stream_filter_v2.md
Name: conv3x3_stream_filter_v2

Overview:
Parametrised 3x3 signed-kernel convolution filter on an Avalon-ST pixel stream. It generalises the first-generation convolution filter in four ways: configurable pixel and coefficient widths, a rounding normalisation shift, an absolute-value output mode, and full ready/valid backpressure. It also adds per-frame kernel latching, SOP resynchronisation and frame-length error reporting. It sits between the pixel source and downstream image stages; output is the (WIDTH-2)x(HEIGHT-2) valid-window image.

Parameters:
WIDTH, 320, pixels per line (>=3)
HEIGHT, 240, lines per frame (>=3)
DATA_W, 8, unsigned pixel width in and out
COEF_W, 8, signed kernel coefficient width
SHIFT, 0, arithmetic right shift applied to the sum (0..15), round-half-up

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
k11..k33  in  9 x COEF_W  signed kernel, row-major; k22 is the centre
mode_abs  in  1  0: clamp negative results to 0; 1: use |result|
data_in  in  DATA_W  input pixel
startofpacket_in  in  1  first pixel of frame
endofpacket_in  in  1  last pixel of frame
valid_in  in  1  input valid
ready_out  out  1  block can accept input
data_out  out  DATA_W  filtered pixel
startofpacket_out  out  1  first output pixel of frame
endofpacket_out  out  1  last output pixel of frame
valid_out  out  1  output valid
ready_in  in  1  downstream ready
frame_error  out  1  one-cycle pulse on malformed frame

Behaviour:
- Reset (async, active-high) clears all of the following:
  - outputs: valid_out, data_out, startofpacket_out, endofpacket_out, frame_error all 0
  - col/row counters to 0, line buffers to 0, latched kernel and mode to 0
  - pipeline valid bits to 0
- Reset asserted mid-frame discards the partial frame. The next accepted pixel is treated as (0,0).
- Handshake:
  - An input beat is accepted when valid_in && ready_out.
  - An output beat completes when valid_out && ready_in.
  - Two-stage pipeline: stage 1 holds sum and flags; stage 2 is the output register.
  - advance = !valid_out || ready_in. ready_out = advance (combinational from ready_in and valid_out only).
  - When advance=0, all pipeline registers, counters and line buffers hold.
  - data_out/SOP/EOP stay stable while valid_out && !ready_in.
- Latency: a pixel that completes a window at (row>=2, col>=2) is accepted in cycle N and appears on valid_out in cycle N+2 when ready_in is held high. Sustained throughput is 1 pixel/cycle.
- Position tracking:
  - col increments per accepted beat and wraps at WIDTH-1, incrementing row.
  - After (HEIGHT-1, WIDTH-1), both counters wrap to 0.
  - An accepted startofpacket_in forces this pixel to (0,0) regardless of the counters (resync).
- Kernel latching: k11..k33 and mode_abs are captured on the accepted pixel at (0,0). The captured values are used for the entire frame; input changes mid-frame have no effect until the next frame.
- Window: rows r-2, r-1, r; cols c-2, c-1, c. The bottom-right tap is the current data_in. Two line memories of WIDTH x DATA_W hold the prior rows.
- Arithmetic:
  - Each tap is zero-extended to signed DATA_W+1 bits; products are DATA_W+COEF_W+1 bits.
  - Sum width is DATA_W+COEF_W+5. There is no overflow for any input.
  - If SHIFT>0, add 2^(SHIFT-1), then arithmetic shift right by SHIFT.
  - If mode_abs, take the magnitude. Then clamp to [0, 2^DATA_W-1].
- Output flags:
  - startofpacket_out accompanies the pixel from window (2,2).
  - endofpacket_out accompanies the pixel from (HEIGHT-1, WIDTH-1).
  - Exactly (WIDTH-2)*(HEIGHT-2) output beats per well-formed frame.
- frame_error pulses for one cycle (independent of ready_in) when either:
  - endofpacket_in is accepted at a position other than (HEIGHT-1, WIDTH-1), or
  - startofpacket_in is accepted at a position other than (0,0).
- Simultaneous SOP and EOP on one beat: SOP resync takes priority and the error is flagged. frame_error is the only indication; pixels are not dropped.

Test Plan:
- 4x4 frame, pixels 0..15 row-major, k22=1 with all other taps 0, SHIFT=0, ready_in=1 -> outputs 5,6,9,10; SOP with 5, EOP with 10; first valid_out 2 cycles after pixel 10 is accepted.
- 4x4 constant 100, all k=1, SHIFT=3 -> every output is (900+4)>>3 = 113.
- Ramp 4r+c, kernel [1 0 -1; 2 0 -2; 1 0 -1] -> mode_abs=0 gives 0 for all outputs; mode_abs=1 gives 8 for all.
- Repeat test 1 with ready_in toggling 1,0,0,1 and random valid_in gaps -> same 4 values in order, no duplicates or drops, outputs stable while stalled, ready_out low whenever valid_out && !ready_in.
- Change the kernel mid-frame to all-zero -> the current frame is unaffected; the next frame outputs all 0.
- SOP injected at pixel 7 of a 4x4 frame -> frame_error pulse; the frame restarts and the following 16 pixels produce a correct 2x2 output. EOP at pixel 9 -> frame_error pulse.
- Assert reset during row 2 -> all outputs 0 immediately; the following clean frame produces correct results.
